// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
//
// Shared definitions for the WS2812 frame-source arbiter and its helpers.
//   PIX_W           : width of one GRB pixel word
//   BLACK_PIX       : the all-off pixel sent during blanking frames
//   src_mux_state_t : arbiter states
//   is_guard_state  : true for the two idle-gap states that run the guard
//                     counter
// ----------------------------------------------------------------------------
package ws2812_pkg;

  localparam int PIX_W = 24;

  localparam logic [PIX_W-1:0] BLACK_PIX = 24'h0;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FRAME       = 3'd1,
    ST_GUARD       = 3'd2,
    ST_BLANK       = 3'd3,
    ST_BLANK_GUARD = 3'd4
  } src_mux_state_t;

  // Both gap states share one guard counter, so a single predicate keeps the
  // counter enable and the state machine in agreement.
  function automatic logic is_guard_state(input src_mux_state_t s);
    return (s == ST_GUARD) || (s == ST_BLANK_GUARD);
  endfunction

endpackage

// File: rtl/ws2812_pix_cnt.sv
// ----------------------------------------------------------------------------
// ws2812_pix_cnt
//
// Pixel counter with terminal-count flag plus a saturating guard counter.
// Used by the arbiter for both real frames and blanking frames.
//
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   pix_inc          : advance the pixel counter (one pixel handshake)
//   guard_run        : guard counter counts while high, clears while low
//   pix_cnt          : current pixel index, 0 .. LED_NUM-1
//   pix_last         : pix_cnt is at LED_NUM-1
//   guard_last       : guard counter is on the final gap cycle
//
// GUARD_CYC is expected to be at least 1.
// ----------------------------------------------------------------------------
module ws2812_pix_cnt #(
  parameter int LED_NUM   = 64,
  parameter int NUM_W     = $clog2(LED_NUM),
  parameter int GUARD_CYC = 1600,
  parameter int GUARD_W   = $clog2(GUARD_CYC + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pix_inc,
  input  logic             guard_run,
  output logic [NUM_W-1:0] pix_cnt,
  output logic             pix_last,
  output logic             guard_last
);

  localparam logic [NUM_W-1:0]   PIX_TERM   = NUM_W'(LED_NUM - 1);
  localparam logic [GUARD_W-1:0] GUARD_TERM = GUARD_W'(GUARD_CYC - 1);
  localparam logic [GUARD_W-1:0] GUARD_MAX  = GUARD_W'(GUARD_CYC);

  logic [NUM_W-1:0]   pix_cnt_q;
  logic [NUM_W-1:0]   pix_cnt_d;
  logic [GUARD_W-1:0] guard_cnt_q;
  logic [GUARD_W-1:0] guard_cnt_d;

  assign pix_cnt    = pix_cnt_q;
  assign pix_last   = (pix_cnt_q == PIX_TERM);
  assign guard_last = (guard_cnt_q == GUARD_TERM);

  // The pixel counter wraps to zero on the last pixel so the next frame
  // always starts from index 0 without a separate clear.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (pix_inc) begin
      pix_cnt_d = pix_last ? '0 : pix_cnt_q + 1'b1;
    end
  end

  // The guard counter clears on its final cycle and whenever no gap is in
  // progress, so every gap starts counting from zero. Saturation only guards
  // against an enable held past the terminal count.
  always_comb begin
    guard_cnt_d = '0;
    if (guard_run && !guard_last) begin
      guard_cnt_d = (guard_cnt_q == GUARD_MAX) ? guard_cnt_q : guard_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pix_cnt_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

endmodule

// File: rtl/ws2812_src_mux.sv
// ----------------------------------------------------------------------------
// ws2812_src_mux
//
// Arbiter between NUM_SRC WS2812 pattern generators and a single ws2812_ctrl
// serialiser. Keys go to the active source only; the active source's start,
// pixel index and pixel data are forwarded. Mode changes are taken only
// between frames, optionally with one all-black frame in between.
//
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   mode_req         : requested source (out-of-range values are ignored)
//   key_in           : debounced key pulses
//   src_key          : per-source key slices, registered
//   src_start        : per-source frame-start requests
//   src_num          : per-source pixel index
//   src_data         : per-source GRB pixel data
//   src_cfg_start    : pixel request, only to the active source in a frame
//   cfg_start        : pixel request pulse from ws2812_ctrl
//   ws2812_start     : frame start to ws2812_ctrl
//   cfg_num          : pixel index to ws2812_ctrl
//   cfg_data         : pixel data to ws2812_ctrl
//   mode             : committed active source
//   switching        : a mode change is in progress
// ----------------------------------------------------------------------------
module ws2812_src_mux
  import ws2812_pkg::*;
#(
  parameter int NUM_SRC         = 3,
  parameter int KEY_W           = 5,
  parameter int LED_NUM         = 64,
  parameter int NUM_W           = $clog2(LED_NUM),
  parameter int MODE_W          = $clog2(NUM_SRC),
  parameter int GUARD_CYC       = 1600,
  parameter int BLANK_ON_SWITCH = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [MODE_W-1:0]        mode_req,
  input  logic [KEY_W-1:0]         key_in,
  output logic [NUM_SRC*KEY_W-1:0] src_key,
  input  logic [NUM_SRC-1:0]       src_start,
  input  logic [NUM_SRC*NUM_W-1:0] src_num,
  input  logic [NUM_SRC*PIX_W-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_cfg_start,
  input  logic                     cfg_start,
  output logic                     ws2812_start,
  output logic [NUM_W-1:0]         cfg_num,
  output logic [PIX_W-1:0]         cfg_data,
  output logic [MODE_W-1:0]        mode,
  output logic                     switching
);

  localparam logic [MODE_W:0] NUM_SRC_M = (MODE_W + 1)'(NUM_SRC);

  src_mux_state_t state_q, state_d;
  logic [MODE_W-1:0]        mode_q, mode_d;
  logic [MODE_W-1:0]        tgt_mode_q, tgt_mode_d;
  logic                     switching_q, switching_d;
  logic                     blank_first_q, blank_first_d;
  logic [NUM_W-1:0]         last_num_q, last_num_d;
  logic [PIX_W-1:0]         last_data_q, last_data_d;
  logic [NUM_SRC*KEY_W-1:0] src_key_q, src_key_d;

  logic [NUM_SRC-1:0] sel_onehot;
  logic               sel_start;
  logic [NUM_W-1:0]   sel_num;
  logic [PIX_W-1:0]   sel_data;
  logic               req_valid;
  logic               switch_req;

  logic               pix_inc;
  logic               guard_run;
  logic [NUM_W-1:0]   pix_cnt;
  logic               pix_last;
  logic               guard_last;

  ws2812_pix_cnt #(
    .LED_NUM   (LED_NUM),
    .NUM_W     (NUM_W),
    .GUARD_CYC (GUARD_CYC)
  ) u_pix_cnt (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .pix_inc    (pix_inc),
    .guard_run  (guard_run),
    .pix_cnt    (pix_cnt),
    .pix_last   (pix_last),
    .guard_last (guard_last)
  );

  assign mode      = mode_q;
  assign switching = switching_q;
  assign src_key   = src_key_q;

  // Select the committed source's inputs. A loop compare is used instead of
  // a variable index so that unused mode codes (e.g. 3 of 3 sources) can
  // never address past the end of the source buses.
  always_comb begin
    sel_onehot = '0;
    sel_start  = 1'b0;
    sel_num    = '0;
    sel_data   = BLACK_PIX;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q == MODE_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_start     = src_start[i];
        sel_num       = src_num[i*NUM_W +: NUM_W];
        sel_data      = src_data[i*PIX_W +: PIX_W];
      end
    end
  end

  assign req_valid  = ({1'b0, mode_req} < NUM_SRC_M);
  assign switch_req = req_valid && (mode_req != mode_q);
  assign guard_run  = is_guard_state(state_q);

  // Keys follow the committed mode one cycle later and are withheld from
  // every source while a switch is pending, so no generator reacts to a key
  // meant for its successor.
  always_comb begin
    src_key_d = '0;
    if (!switching_q) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (mode_q == MODE_W'(i)) begin
          src_key_d[i*KEY_W +: KEY_W] = key_in;
        end
      end
    end
  end

  // Main arbiter. Switch requests are only looked at in IDLE, which both
  // defers them to frame boundaries and ignores requests that change while
  // blanking; those are picked up again once IDLE is reached.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    tgt_mode_d    = tgt_mode_q;
    switching_d   = switching_q;
    blank_first_d = 1'b0;
    last_num_d    = last_num_q;
    last_data_d   = last_data_q;
    pix_inc       = 1'b0;
    ws2812_start  = 1'b0;
    cfg_num       = '0;
    cfg_data      = BLACK_PIX;
    src_cfg_start = '0;

    case (state_q)
      ST_IDLE: begin
        // Without blanking the switch completes here, so the flag is only
        // ever high for the single cycle after the request.
        switching_d = 1'b0;
        if (switch_req) begin
          tgt_mode_d  = mode_req;
          switching_d = 1'b1;
          if (BLANK_ON_SWITCH != 0) begin
            state_d       = ST_BLANK;
            blank_first_d = 1'b1;
          end else begin
            mode_d = mode_req;
          end
        end else if (sel_start) begin
          ws2812_start = 1'b1;
          state_d      = ST_FRAME;
        end
      end

      ST_FRAME: begin
        cfg_num       = sel_num;
        cfg_data      = sel_data;
        last_num_d    = sel_num;
        last_data_d   = sel_data;
        src_cfg_start = sel_onehot & {NUM_SRC{cfg_start}};
        pix_inc       = cfg_start;
        if (cfg_start && pix_last) begin
          state_d = ST_GUARD;
        end
      end

      // The source may already be preparing its next frame, so the last
      // forwarded pixel is replayed from local copies rather than live.
      ST_GUARD: begin
        cfg_num  = last_num_q;
        cfg_data = last_data_q;
        if (guard_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_BLANK: begin
        ws2812_start = blank_first_q;
        cfg_num      = pix_cnt;
        pix_inc      = cfg_start;
        if (cfg_start && pix_last) begin
          state_d = ST_BLANK_GUARD;
        end
      end

      ST_BLANK_GUARD: begin
        if (guard_last) begin
          mode_d      = tgt_mode_q;
          switching_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= '0;
      tgt_mode_q    <= '0;
      switching_q   <= 1'b0;
      blank_first_q <= 1'b0;
      last_num_q    <= '0;
      last_data_q   <= BLACK_PIX;
      src_key_q     <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      tgt_mode_q    <= tgt_mode_d;
      switching_q   <= switching_d;
      blank_first_q <= blank_first_d;
      last_num_q    <= last_num_d;
      last_data_q   <= last_data_d;
      src_key_q     <= src_key_d;
    end
  end

endmodule

// File: tb/tb_ws2812_src_mux.sv
// ----------------------------------------------------------------------------
// tb_ws2812_src_mux
//
// Directed bench for ws2812_src_mux with default parameters (3 sources,
// 64 pixels, 1600-cycle guard, blanking on). Pixel expectations are queued
// when a pixel request is driven and popped when the forwarded pixel is
// sampled.
// ----------------------------------------------------------------------------
module tb_ws2812_src_mux;

  localparam int NUM_SRC   = 3;
  localparam int KEY_W     = 5;
  localparam int LED_NUM   = 64;
  localparam int NUM_W     = 6;
  localparam int MODE_W    = 2;
  localparam int GUARD_CYC = 1600;

  typedef struct packed {
    logic [NUM_W-1:0] num;
    logic [23:0]      data;
  } pix_t;

  logic                     sys_clk;
  logic                     sys_rst;
  logic [MODE_W-1:0]        mode_req;
  logic [KEY_W-1:0]         key_in;
  logic [NUM_SRC*KEY_W-1:0] src_key;
  logic [NUM_SRC-1:0]       src_start;
  logic [NUM_SRC*NUM_W-1:0] src_num;
  logic [NUM_SRC*24-1:0]    src_data;
  logic [NUM_SRC-1:0]       src_cfg_start;
  logic                     cfg_start;
  logic                     ws2812_start;
  logic [NUM_W-1:0]         cfg_num;
  logic [23:0]              cfg_data;
  logic [MODE_W-1:0]        mode;
  logic                     switching;

  int   total = 0;
  int   bad   = 0;
  pix_t sb_q[$];

  ws2812_src_mux dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .mode_req      (mode_req),
    .key_in        (key_in),
    .src_key       (src_key),
    .src_start     (src_start),
    .src_num       (src_num),
    .src_data      (src_data),
    .src_cfg_start (src_cfg_start),
    .cfg_start     (cfg_start),
    .ws2812_start  (ws2812_start),
    .cfg_num       (cfg_num),
    .cfg_data      (cfg_data),
    .mode          (mode),
    .switching     (switching)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] pixData(input int s, input int i);
    logic [7:0] hi;
    logic [7:0] mid;
    hi  = 8'(s * 16 + 1);
    mid = 8'(i);
    return {hi, mid, mid ^ 8'hA5};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Every source presents a distinct index/data pattern for the same pixel
  // step, so forwarding the wrong source is visible.
  task automatic applyStimulus(input int idx, input logic pulse);
    for (int s = 0; s < NUM_SRC; s++) begin
      src_num[s*NUM_W +: NUM_W] = NUM_W'((idx + s * 7) % LED_NUM);
      src_data[s*24 +: 24]      = pixData(s, idx);
    end
    cfg_start = pulse;
  endtask

  task automatic doPixels(input int m, input int first, input int last, input logic blank);
    pix_t e;
    for (int i = first; i <= last; i++) begin
      applyStimulus(i, 1'b1);
      if (blank) begin
        sb_q.push_back('{num: NUM_W'(i), data: 24'h0});
      end else begin
        sb_q.push_back('{num: NUM_W'((i + m * 7) % LED_NUM), data: pixData(m, i)});
      end
      #1;
      e = sb_q.pop_front();
      checkOutput(blank ? "blank_num" : "pix_num", 64'(cfg_num), 64'(e.num));
      checkOutput(blank ? "blank_data" : "pix_data", 64'(cfg_data), 64'(e.data));
      checkOutput(blank ? "blank_sel" : "pix_sel", 64'(src_cfg_start),
                  blank ? 64'(0) : 64'(1 << m));
      tick();
    end
    cfg_start = 1'b0;
  endtask

  initial begin
    int errs;
    int n;

    sys_rst   = 1'b1;
    mode_req  = '0;
    key_in    = '0;
    src_start = '0;
    src_num   = '0;
    src_data  = '0;
    cfg_start = 1'b0;
    $display("[TB] reset");
    tick();
    tick();
    checkOutput("rst_mode", 64'(mode), 64'(0));
    checkOutput("rst_switching", 64'(switching), 64'(0));
    checkOutput("rst_src_key", 64'(src_key), 64'(0));
    checkOutput("rst_ws_start", 64'(ws2812_start), 64'(0));
    checkOutput("rst_src_cfg_start", 64'(src_cfg_start), 64'(0));
    checkOutput("rst_cfg_num", 64'(cfg_num), 64'(0));
    checkOutput("rst_cfg_data", 64'(cfg_data), 64'(0));
    sys_rst = 1'b0;
    tick();

    $display("[TB] frame from source 0");
    src_start = 3'b010;
    #1;
    checkOutput("start_other_src", 64'(ws2812_start), 64'(0));
    src_start = 3'b001;
    #1;
    checkOutput("start0", 64'(ws2812_start), 64'(1));
    tick();
    src_start = '0;
    doPixels(0, 0, LED_NUM - 1, 1'b0);
    applyStimulus(99, 1'b1);
    #1;
    checkOutput("guard_no_fwd", 64'(src_cfg_start), 64'(0));
    checkOutput("guard_hold_num", 64'(cfg_num), 64'(63));
    checkOutput("guard_hold_data", 64'(cfg_data), 64'(pixData(0, 63)));
    cfg_start = 1'b0;
    src_start = 3'b001;
    errs = 0;
    for (int k = 0; k < GUARD_CYC; k++) begin
      #1;
      if (ws2812_start !== 1'b0) errs++;
      tick();
    end
    checkOutput("guard_ignores_start", 64'(errs), 64'(0));
    #1;
    checkOutput("guard_exit_start", 64'(ws2812_start), 64'(1));
    tick();

    $display("[TB] frame 2 with switch to mode 2 requested mid-frame");
    src_start = '0;
    doPixels(0, 0, 9, 1'b0);
    mode_req = 2'd2;
    doPixels(0, 10, LED_NUM - 1, 1'b0);
    checkOutput("mode_held_frame", 64'(mode), 64'(0));
    src_start = 3'b001;
    errs = 0;
    for (int k = 0; k < GUARD_CYC; k++) begin
      #1;
      if (ws2812_start !== 1'b0 || mode !== 2'd0 || switching !== 1'b0) errs++;
      tick();
    end
    checkOutput("guard2_held", 64'(errs), 64'(0));
    #1;
    checkOutput("switch_wins_start", 64'(ws2812_start), 64'(0));
    tick();
    src_start = '0;
    #1;
    checkOutput("blank_start", 64'(ws2812_start), 64'(1));
    checkOutput("blank_switching", 64'(switching), 64'(1));
    checkOutput("blank_mode_old", 64'(mode), 64'(0));
    doPixels(0, 0, 0, 1'b1);
    #1;
    checkOutput("blank_start_once", 64'(ws2812_start), 64'(0));
    doPixels(0, 1, LED_NUM - 1, 1'b1);
    n = 0;
    while (mode !== 2'd2 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("blank_guard_len", 64'(n), 64'(GUARD_CYC));
    checkOutput("mode2_done", 64'(mode), 64'(2));
    checkOutput("mode2_switching", 64'(switching), 64'(0));

    $display("[TB] key routing in mode 2");
    key_in = 5'b00100;
    tick();
    checkOutput("key_mode2", 64'(src_key), 64'(15'h1000));
    key_in = '0;
    tick();
    checkOutput("key_mode2_clear", 64'(src_key), 64'(0));

    $display("[TB] switch to mode 1 racing a start from source 2");
    mode_req  = 2'd1;
    src_start = 3'b100;
    #1;
    checkOutput("switch_wins_src2", 64'(ws2812_start), 64'(0));
    tick();
    src_start = '0;
    key_in    = 5'b00100;
    #1;
    checkOutput("blank2_switching", 64'(switching), 64'(1));
    checkOutput("blank2_start", 64'(ws2812_start), 64'(1));
    tick();
    checkOutput("key_blocked", 64'(src_key), 64'(0));
    key_in = '0;
    doPixels(0, 0, LED_NUM - 1, 1'b1);
    n = 0;
    while (mode !== 2'd1 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("mode1_done", 64'(mode), 64'(1));
    checkOutput("mode1_switching", 64'(switching), 64'(0));
    key_in = 5'b00100;
    tick();
    checkOutput("key_mode1", 64'(src_key), 64'(15'h0080));
    key_in = '0;
    tick();
    checkOutput("key_mode1_clear", 64'(src_key), 64'(0));

    $display("[TB] out-of-range mode request");
    mode_req = 2'd3;
    tick();
    tick();
    checkOutput("bad_req_mode", 64'(mode), 64'(1));
    checkOutput("bad_req_switching", 64'(switching), 64'(0));
    mode_req = 2'd1;

    $display("[TB] reset in the middle of a frame");
    src_start = 3'b010;
    #1;
    checkOutput("start1", 64'(ws2812_start), 64'(1));
    tick();
    src_start = '0;
    key_in    = 5'b00100;
    doPixels(1, 0, 29, 1'b0);
    applyStimulus(30, 1'b1);
    sys_rst  = 1'b1;
    mode_req = 2'd0;
    tick();
    checkOutput("midrst_mode", 64'(mode), 64'(0));
    checkOutput("midrst_switching", 64'(switching), 64'(0));
    checkOutput("midrst_src_key", 64'(src_key), 64'(0));
    checkOutput("midrst_ws_start", 64'(ws2812_start), 64'(0));
    checkOutput("midrst_src_cfg_start", 64'(src_cfg_start), 64'(0));
    checkOutput("midrst_cfg_num", 64'(cfg_num), 64'(0));
    checkOutput("midrst_cfg_data", 64'(cfg_data), 64'(0));
    sys_rst   = 1'b0;
    key_in    = '0;
    cfg_start = 1'b0;
    tick();

    $display("[TB] full frame after reset starts from pixel 0");
    src_start = 3'b001;
    #1;
    checkOutput("start0_post_rst", 64'(ws2812_start), 64'(1));
    tick();
    src_start = '0;
    doPixels(0, 0, LED_NUM - 1, 1'b0);
    applyStimulus(64, 1'b1);
    #1;
    checkOutput("post_rst_frame_end", 64'(src_cfg_start), 64'(0));
    cfg_start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_src_mux.md
# ws2812_src_mux

Parametrised frame-source arbiter between NUM_SRC WS2812 pattern generators (menu/select, find, draw, …) and the single `ws2812_ctrl` serialiser. It routes debounced keys to the active source and forwards that source's start, pixel index and pixel data. Mode changes are deferred to frame boundaries, with an optional all-black blanking frame between sources. This replaces the hard-wired three-way combinational mode mux at the top level.

## Interface
- NUM_SRC, 3: number of frame sources (≥2)
- KEY_W, 5: key vector width
- LED_NUM, 64: pixels per frame
- NUM_W, $clog2(LED_NUM): pixel index width
- MODE_W, $clog2(NUM_SRC): mode select width
- GUARD_CYC, 1600: idle cycles after the last pixel before a switch or blank may start
- BLANK_ON_SWITCH, 1: 1 = insert one all-zero frame on every mode change
- sys_clk  in  1  single clock; all logic on its rising edge
- sys_rst  in  1  synchronous, active-high reset
- mode_req  in  MODE_W  requested source; values ≥NUM_SRC ignored
- key_in  in  KEY_W  debounced key pulses
- src_key  out  NUM_SRC*KEY_W  per-source key slices, registered
- src_start  in  NUM_SRC  per-source frame-start requests
- src_num  in  NUM_SRC*NUM_W  per-source pixel index
- src_data  in  NUM_SRC*24  per-source GRB pixel data
- src_cfg_start  out  NUM_SRC  pixel request, gated to the active source only
- cfg_start  in  1  pixel request pulse from ws2812_ctrl
- ws2812_start  out  1  frame start to ws2812_ctrl
- cfg_num  out  NUM_W  pixel index to ws2812_ctrl
- cfg_data  out  24  pixel data to ws2812_ctrl
- mode  out  MODE_W  committed active source
- switching  out  1  high while a mode change is in progress

## Operation
- States: IDLE, FRAME, GUARD, BLANK, BLANK_GUARD.
- Reset values: state=IDLE, mode=0, tgt_mode=0, pix_cnt=0, guard_cnt=0, src_key=0, switching=0. Combinational outputs at reset: ws2812_start=0, src_cfg_start=0, cfg_num=0, cfg_data=0.
- IDLE:
  - If mode_req is valid and ≠mode: latch tgt_mode←mode_req and set switching=1.
    - BLANK_ON_SWITCH=1: go to BLANK.
    - BLANK_ON_SWITCH=0: mode←tgt_mode, stay in IDLE.
  - Else if src_start[mode]=1: ws2812_start=1 in the same cycle, go to FRAME.
  - A switch wins over a simultaneous src_start; that start is dropped.
- FRAME:
  - cfg_num = src_num[mode], cfg_data = src_data[mode].
  - src_cfg_start[mode] = cfg_start; all other bits 0.
  - pix_cnt increments on each cfg_start.
  - On cfg_start with pix_cnt=LED_NUM-1: pix_cnt←0, go to GUARD.
- GUARD: count GUARD_CYC cycles, then go to IDLE. Outputs hold the last forwarded values; src_start is ignored.
- BLANK:
  - ws2812_start=1 on the first cycle only.
  - cfg_data=0, cfg_num=pix_cnt.
  - cfg_start is not forwarded to any source.
  - After LED_NUM cfg_start pulses, go to BLANK_GUARD.
- BLANK_GUARD: wait GUARD_CYC cycles, then mode←tgt_mode, switching←0, go to IDLE.
- If mode_req changes during BLANK or BLANK_GUARD, tgt_mode is not updated. The new request is handled from IDLE on the next cycle.
- Key routing, registered every cycle:
  - src_key slice[mode] ← key_in when switching=0; every other slice ← 0.
  - All slices ← 0 while switching=1.
- Width rules:
  - pix_cnt is NUM_W bits and never exceeds LED_NUM-1.
  - guard_cnt is $clog2(GUARD_CYC+1) bits and saturates.

## Timing
- ws2812_start, cfg_num, cfg_data and src_cfg_start are combinational from the registered state and mode (zero added latency in FRAME).
- src_key has 1-cycle latency from key_in.
- Mode change without blanking: mode updates the cycle after IDLE sees the request.
- Mode change with blanking: ≥ 1 + LED_NUM pixel handshakes + GUARD_CYC cycles.
- A switch requested during FRAME waits for the last pixel plus GUARD_CYC.
- A sys_rst asserted mid-frame or mid-blank returns every register to its reset value on the next edge; no partial frame is resumed.

## Structure
- Shared package ws2812_pkg: `PIX_W=24`, state enum `src_mux_state_t`, `BLACK_PIX=24'h0`.
- One sub-module: `ws2812_pix_cnt`, a pixel counter with terminal-count flag and a saturating guard counter, reused by FRAME and BLANK.

## Test plan
- Reset, then src_start[0] pulse → ws2812_start same cycle; 64 cfg_start pulses forward src_data[0]; IDLE reached 1600 cycles after the last pulse.
- mode_req 0→2 mid-frame → mode stays 0 until frame end + GUARD.
  - Then one blank frame: 64 pixels with cfg_data=0.
  - Then mode=2 and switching=0.
- mode_req=2 and src_start[0] in the same IDLE cycle → no ws2812_start from source 0; switch begins.
- key_in=5'b00100 with mode=1 → src_key[9:5]=00100 next cycle, other slices 0; during switching=1 all slices 0.
- mode_req=3 with NUM_SRC=3 → ignored; mode unchanged; switching stays 0.
- sys_rst asserted at pixel 30 of a frame → next cycle state=IDLE, pix_cnt=0, mode=0, all outputs 0.
